// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters.
// Round-robin arbitration, operands registered onto the ALU, a fixed settle
// time, then the captured result is returned to the winner. One op in flight.
module alu_share_arbiter #(
    parameter int unsigned EXEC_CYCLES = 1,  // settle cycles before capture, 1..15
    parameter int unsigned CNT_W       = 4   // 2**CNT_W must exceed EXEC_CYCLES
) (
    input  logic        clk,
    input  logic        reset,        // asynchronous, active-low

    // Request side
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req0_A,
    input  logic [31:0] req0_B,
    input  logic [5:0]  req0_ALUFun,
    input  logic        req0_Sign,
    input  logic [31:0] req1_A,
    input  logic [31:0] req1_B,
    input  logic [5:0]  req1_ALUFun,
    input  logic        req1_Sign,

    // Shared ALU
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [5:0]  alu_ALUFun,
    output logic        alu_Sign,
    input  logic [31:0] alu_S,

    // Response side
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_S,

    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_t;

    // Count value on which alu_S is captured.
    localparam logic [CNT_W-1:0] LastCount = CNT_W'(EXEC_CYCLES - 1);

    state_t           state;
    logic             grant;       // requester owning the op in flight
    logic             last_grant;  // most recent winner; loses the next tie
    logic [CNT_W-1:0] count;

    logic             accept;
    logic             win;

    // Combinational ready: only in IDLE, a tie goes to the requester that did not win last.
    always_comb begin
        req_ready = 2'b00;
        if (state == StIdle) begin
            unique case (req_valid)
                2'b01:   req_ready = 2'b01;
                2'b10:   req_ready = 2'b10;
                2'b11:   req_ready = last_grant ? 2'b01 : 2'b10;
                default: req_ready = 2'b00;
            endcase
        end
    end

    // Handshake detect; req_ready is one-hot so bit 1 names the winner.
    always_comb begin
        accept = |(req_valid & req_ready);
        win    = req_ready[1];
        busy   = (state != StIdle);
    end

    // Main FSM with all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= StIdle;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            count      <= '0;
            alu_A      <= '0;
            alu_B      <= '0;
            alu_ALUFun <= '0;
            alu_Sign   <= 1'b0;
            rsp_S      <= '0;
            rsp_valid  <= 2'b00;
        end else begin
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        alu_A      <= win ? req1_A      : req0_A;
                        alu_B      <= win ? req1_B      : req0_B;
                        alu_ALUFun <= win ? req1_ALUFun : req0_ALUFun;
                        alu_Sign   <= win ? req1_Sign   : req0_Sign;
                        grant      <= win;
                        last_grant <= win;
                        count      <= '0;
                        state      <= StExec;
                    end
                end
                StExec: begin
                    // ALU inputs are held; capture once they have settled long enough.
                    count <= count + 1'b1;
                    if (count == LastCount) begin
                        rsp_S     <= alu_S;
                        rsp_valid <= grant ? 2'b10 : 2'b01;
                        state     <= StResp;
                    end
                end
                StResp: begin
                    // Only the granted requester's rsp_ready matters.
                    if (rsp_ready[grant]) begin
                        rsp_valid <= 2'b00;
                        state     <= StIdle;
                    end
                end
                default: begin
                    rsp_valid <= 2'b00;
                    state     <= StIdle;
                end
            endcase
        end
    end

endmodule
